// File: rtl/osd_wr_sched.sv
// OSD bitmap RAM write scheduler: shares one write port between host
// single-word writes and a solid-colour rectangle-fill engine.
//
// Ports:
//   clk_in, rst            : OSD AXI clock, synchronous active-high reset
//   hst_wreq/waddr/wdata   : host write request (held until accepted)
//   hst_wack               : combinational host accept
//   cmd_*                  : fill command (valid/ready handshake)
//   abort                  : abandon the running fill
//   osd_waddr/wdata/wreq   : registered RAM write port
//   busy, done, err        : fill status (busy in FILL, done pulse, sticky err)
module osd_wr_sched #(
   parameter int C_DEPTH_WORDS  = 32768,
   parameter int C_HOST_MAX_RUN = 4
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        hst_wreq,
   input  logic [15:0] hst_waddr,
   input  logic [31:0] hst_wdata,
   output logic        hst_wack,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [11:0] cmd_x,
   input  logic [11:0] cmd_y,
   input  logic [11:0] cmd_w,
   input  logic [11:0] cmd_h,
   input  logic [11:0] cmd_pitch,
   input  logic [3:0]  cmd_color,
   input  logic        abort,
   output logic [15:0] osd_waddr,
   output logic [31:0] osd_wdata,
   output logic        osd_wreq,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE
   } state_t;

   localparam logic [31:0] DEPTH   = 32'(C_DEPTH_WORDS);
   localparam logic [3:0]  MAX_RUN = 4'(C_HOST_MAX_RUN);

   state_t      state;
   state_t      state_nx;

   logic [11:0] f_w;
   logic [11:0] f_h;
   logic [11:0] f_pitch;
   logic [3:0]  f_color;
   logic [11:0] col;
   logic [11:0] row;
   logic [15:0] row_base;
   logic [3:0]  host_run;

   logic [31:0] end_addr;
   logic        cmd_take;
   logic        cmd_null;
   logic        cmd_bad;
   logic        fill_want;
   logic        hst_grant;
   logic        fill_grant;
   logic        col_last;
   logic        row_last;

   // Last word the rectangle touches, evaluated at full width so that
   // oversized commands cannot wrap back into the legal range.
   assign end_addr = (32'(cmd_y) + 32'(cmd_h) - 32'd1) * 32'(cmd_pitch)
                   + 32'(cmd_x) + 32'(cmd_w) - 32'd1;

   // Empty rectangles finish quietly; their end address is meaningless.
   assign cmd_null = (cmd_w == 12'd0) || (cmd_h == 12'd0);
   assign cmd_bad  = !cmd_null &&
                     ((end_addr >= DEPTH) ||
                      ((13'(cmd_x) + 13'(cmd_w)) > 13'(cmd_pitch)));

   assign cmd_ready = (state == S_IDLE);
   assign cmd_take  = cmd_valid & cmd_ready;

   // The fill yields to the host except after MAX_RUN straight host
   // grants, which forces one fill slot so the fill cannot starve.
   assign fill_want  = (state == S_FILL) && !abort;
   assign hst_wack   = hst_wreq && !(fill_want && (host_run == MAX_RUN));
   assign hst_grant  = hst_wreq & hst_wack;
   assign fill_grant = fill_want && !hst_grant;

   assign col_last = (col == f_w - 12'd1);
   assign row_last = (row == f_h - 12'd1);

   assign busy = (state == S_FILL);
   assign done = (state == S_DONE);

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (cmd_take) begin
               if (cmd_null || cmd_bad) state_nx = S_DONE;
               else                     state_nx = S_FILL;
            end
         end
         S_FILL: begin
            if (abort)
               state_nx = S_DONE;
            else if (fill_grant && col_last && row_last)
               state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= S_IDLE;
         osd_wreq  <= 1'b0;
         osd_waddr <= 16'd0;
         osd_wdata <= 32'd0;
         err       <= 1'b0;
         f_w       <= 12'd0;
         f_h       <= 12'd0;
         f_pitch   <= 12'd0;
         f_color   <= 4'd0;
         col       <= 12'd0;
         row       <= 12'd0;
         row_base  <= 16'd0;
         host_run  <= 4'd0;
      end else begin
         state    <= state_nx;
         osd_wreq <= hst_grant | fill_grant;

         if (hst_grant) begin
            osd_waddr <= hst_waddr;
            osd_wdata <= hst_wdata;
         end else if (fill_grant) begin
            osd_waddr <= row_base + 16'(col);
            osd_wdata <= {8{f_color}};
         end

         if ((state != S_FILL) || fill_grant)
            host_run <= 4'd0;
         else if (hst_grant)
            host_run <= host_run + 4'd1;

         if (cmd_take) begin
            f_w      <= cmd_w;
            f_h      <= cmd_h;
            f_pitch  <= cmd_pitch;
            f_color  <= cmd_color;
            col      <= 12'd0;
            row      <= 12'd0;
            // The only multiply; rows advance by adding pitch.
            row_base <= 16'(cmd_y) * 16'(cmd_pitch) + 16'(cmd_x);
            err      <= cmd_bad;
         end else if (fill_grant) begin
            if (col_last) begin
               col      <= 12'd0;
               row      <= row + 12'd1;
               row_base <= row_base + 16'(f_pitch);
            end else begin
               col <= col + 12'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_osd_wr_sched.sv
// Scoreboard bench for osd_wr_sched: stimulus pushes expected port writes,
// a negedge monitor pops and compares every osd_wreq beat.
module tb_osd_wr_sched;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        hst_wreq = 1'b0;
   logic [15:0] hst_waddr = 16'd0;
   logic [31:0] hst_wdata = 32'd0;
   logic        hst_wack;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [11:0] cmd_x = 12'd0;
   logic [11:0] cmd_y = 12'd0;
   logic [11:0] cmd_w = 12'd0;
   logic [11:0] cmd_h = 12'd0;
   logic [11:0] cmd_pitch = 12'd0;
   logic [3:0]  cmd_color = 4'd0;
   logic        abort = 1'b0;
   logic [15:0] osd_waddr;
   logic [31:0] osd_wdata;
   logic        osd_wreq;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t   exp_q[$];
   wr_t   mon_e;
   int    total = 0;
   int    bad = 0;
   bit    mon_on = 1'b0;

   osd_wr_sched dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .hst_wreq  (hst_wreq),
      .hst_waddr (hst_waddr),
      .hst_wdata (hst_wdata),
      .hst_wack  (hst_wack),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .cmd_w     (cmd_w),
      .cmd_h     (cmd_h),
      .cmd_pitch (cmd_pitch),
      .cmd_color (cmd_color),
      .abort     (abort),
      .osd_waddr (osd_waddr),
      .osd_wdata (osd_wdata),
      .osd_wreq  (osd_wreq),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [31:0] d);
      wr_t t;
      t.a = a;
      t.d = d;
      exp_q.push_back(t);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_cmd(input logic [11:0] x, input logic [11:0] y,
                           input logic [11:0] w, input logic [11:0] h,
                           input logic [11:0] p, input logic [3:0] c);
      cmd_x = x;
      cmd_y = y;
      cmd_w = w;
      cmd_h = h;
      cmd_pitch = p;
      cmd_color = c;
      cmd_valid = 1'b1;
      @(negedge clk_in);
      chk1("cmd_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
   endtask

   always @(negedge clk_in) begin
      if (mon_on && osd_wreq === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h want none",
                     osd_waddr, osd_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(osd_waddr), 32'(mon_e.a));
            chk("wr_data", osd_wdata, mon_e.d);
         end
      end
   end

   logic [15:0] fa [6];
   int          k;
   bit          fslot;

   initial begin
      fa[0] = 16'd32; fa[1] = 16'd33; fa[2] = 16'd34;
      fa[3] = 16'd42; fa[4] = 16'd43; fa[5] = 16'd44;

      // reset state
      rst = 1'b1;
      step(); step(); step();
      @(negedge clk_in);
      chk1("rst_wreq", osd_wreq, 1'b0);
      chk("rst_waddr", 32'(osd_waddr), 32'd0);
      chk("rst_wdata", osd_wdata, 32'd0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      step();
      rst = 1'b0;
      mon_on = 1'b1;
      step();

      // host write with no fill
      hst_wreq = 1'b1;
      hst_waddr = 16'h0010;
      hst_wdata = 32'hDEADBEEF;
      @(negedge clk_in);
      chk1("host_wack", hst_wack, 1'b1);
      push(16'h0010, 32'hDEADBEEF);
      step();
      hst_wreq = 1'b0;
      step(); step();

      // uncontended fill
      for (int i = 0; i < 6; i++) push(fa[i], 32'h55555555);
      send_cmd(12'd2, 12'd3, 12'd3, 12'd2, 12'd10, 4'h5);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_in);
         chk1("fill_busy", busy, 1'b1);
         chk1("fill_nodone", done, 1'b0);
         step();
      end
      @(negedge clk_in);
      chk1("fill_done", done, 1'b1);
      chk1("fill_busy_end", busy, 1'b0);
      step();
      @(negedge clk_in);
      chk1("fill_done_pulse", done, 1'b0);
      chk1("fill_idle_ready", cmd_ready, 1'b1);
      step();

      // fill against continuous host traffic: 4 host, 1 fill
      send_cmd(12'd2, 12'd3, 12'd3, 12'd2, 12'd10, 4'h5);
      k = 0;
      for (int c = 0; c < 30; c++) begin
         fslot = (c % 5 == 4);
         hst_wreq = 1'b1;
         hst_waddr = 16'(16'h0200 + k);
         hst_wdata = 32'hC0DE0000 + 32'(k);
         @(negedge clk_in);
         chk1("arb_wack", hst_wack, !fslot);
         if (fslot) push(fa[c / 5], 32'h55555555);
         else begin
            push(hst_waddr, hst_wdata);
            k++;
         end
         step();
      end
      hst_wreq = 1'b0;
      @(negedge clk_in);
      chk1("arb_done", done, 1'b1);
      step(); step();

      // out-of-range command rejected
      send_cmd(12'd0, 12'd4000, 12'd1, 12'd10, 12'd10, 4'h1);
      @(negedge clk_in);
      chk1("rej_err", err, 1'b1);
      chk1("rej_done", done, 1'b1);
      step();
      @(negedge clk_in);
      chk1("rej_err_sticky", err, 1'b1);
      chk1("rej_done_pulse", done, 1'b0);
      step();
      push(16'd0, 32'hAAAAAAAA);
      send_cmd(12'd0, 12'd0, 12'd1, 12'd1, 12'd1, 4'hA);
      @(negedge clk_in);
      chk1("rej_err_clear", err, 1'b0);
      chk1("rej_next_busy", busy, 1'b1);
      step(); step(); step();

      // abort after two fill writes
      push(16'd4, 32'h33333333);
      push(16'd5, 32'h33333333);
      send_cmd(12'd0, 12'd1, 12'd3, 12'd3, 12'd4, 4'h3);
      step();
      step();
      abort = 1'b1;
      @(negedge clk_in);
      chk1("abort_busy", busy, 1'b1);
      step();
      abort = 1'b0;
      @(negedge clk_in);
      chk1("abort_done", done, 1'b1);
      step();
      @(negedge clk_in);
      chk1("abort_ready", cmd_ready, 1'b1);
      chk1("abort_err", err, 1'b0);
      step();

      // null commands
      send_cmd(12'd1, 12'd1, 12'd0, 12'd5, 12'd10, 4'h7);
      @(negedge clk_in);
      chk1("null_w_done", done, 1'b1);
      chk1("null_w_err", err, 1'b0);
      chk1("null_w_busy", busy, 1'b0);
      step(); step();
      send_cmd(12'd1, 12'd1, 12'd5, 12'd0, 12'd10, 4'h7);
      @(negedge clk_in);
      chk1("null_h_done", done, 1'b1);
      chk1("null_h_err", err, 1'b0);
      step(); step();

      // reset mid-fill
      push(16'd4, 32'h33333333);
      push(16'd5, 32'h33333333);
      send_cmd(12'd0, 12'd1, 12'd3, 12'd3, 12'd4, 4'h3);
      step();
      step();
      rst = 1'b1;
      step();
      @(negedge clk_in);
      chk1("mrst_wreq", osd_wreq, 1'b0);
      chk("mrst_waddr", 32'(osd_waddr), 32'd0);
      chk("mrst_wdata", osd_wdata, 32'd0);
      chk1("mrst_busy", busy, 1'b0);
      chk1("mrst_done", done, 1'b0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) step();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/osd_wr_sched.md
Name: osd_wr_sched

Overview:
- Write-side scheduler for the OSD bitmap RAM. It drives the OSD write port (waddr/wdata/wreq, 32-bit words of 8 pixels x 4 bits) in the OSD AXI clock domain.
- It shares that single port between two requesters:
  - host single-word writes (register path);
  - an internal rectangle-fill engine that paints a solid 4-bit colour into a word-aligned rectangle of the bitmap.
- Sits between the AXI-lite register block and the OSD overlay's write port.

Parameters:
- C_DEPTH_WORDS, 32768, OSD RAM depth in 32-bit words; addresses >= this are illegal.
- C_HOST_MAX_RUN, 4, max consecutive host grants while a fill is pending before one fill slot is forced (1..15).

Ports:
- clk_in  in  1  OSD AXI clock
- rst  in  1  synchronous, active-high reset
- hst_wreq  in  1  host write request, held until accepted
- hst_waddr  in  16  host word address
- hst_wdata  in  32  host word data
- hst_wack  out  1  combinational accept; transfer occurs when hst_wreq & hst_wack
- cmd_valid  in  1  fill command valid
- cmd_ready  out  1  high only in IDLE
- cmd_x  in  12  rectangle left edge, in words (8-pixel units)
- cmd_y  in  12  rectangle top row
- cmd_w  in  12  width in words, 0 = null command
- cmd_h  in  12  height in rows, 0 = null command
- cmd_pitch  in  12  words per bitmap row
- cmd_color  in  4  fill nibble, replicated 8x into the word
- abort  in  1  abandon current fill
- osd_waddr  out  16  registered RAM word address
- osd_wdata  out  32  registered RAM data
- osd_wreq  out  1  registered write strobe
- busy  out  1  high in FILL
- done  out  1  one-cycle pulse when a fill ends (normal, null or aborted)
- err  out  1  sticky; set on a rejected command, cleared by rst or the next accepted command

Behaviour:
- Reset values:
  - osd_wreq, osd_waddr, osd_wdata, busy, done, err all 0.
  - State IDLE; all counters 0.
  - Reset mid-fill drops the fill; no further writes are issued.
- States: IDLE, FILL, DONE.
- IDLE, command handshake:
  - A command is taken when cmd_valid & cmd_ready.
  - Latch all cmd_* fields and compute the end address = (cmd_y + cmd_h - 1) * cmd_pitch + cmd_x + cmd_w - 1 at full 32-bit width.
- IDLE, command outcomes:
  - Reject if the end address >= C_DEPTH_WORDS, or if cmd_x + cmd_w > cmd_pitch. A rejected command sets err, pulses done the next cycle, and issues no writes.
  - If cmd_w == 0 or cmd_h == 0, go to DONE without writes and without setting err.
  - Otherwise go to FILL with:
    - row_base = cmd_y * cmd_pitch + cmd_x;
    - col = 0; row = 0.
- FILL, address generation:
  - Each fill slot writes address row_base + col with data = {8{cmd_color}}.
  - col increments after each write.
  - When col == w - 1: set col = 0, row_base += pitch, row += 1.
  - Only incremental adders after the initial multiply.
  - After the write with row == h - 1 and col == w - 1, go to DONE.
- DONE: pulse done for 1 cycle, return to IDLE. busy is low from that cycle on.
- Arbitration, evaluated every cycle; exactly one write per cycle at most:
  - Host wins when hst_wreq = 1, unless the fill is in FILL and host_run == C_HOST_MAX_RUN. In that case the fill gets the slot and hst_wack = 0.
  - host_run counts consecutive host grants while in FILL. It resets to 0 on any fill slot, and is held at 0 outside FILL.
  - With no host request, FILL writes every cycle. A fill of N words with no host traffic takes N cycles; done is asserted in cycle N+1 after FILL entry.
  - In IDLE/DONE, hst_wack = hst_wreq.
- Host pass-through:
  - Accepted host write in cycle T appears on osd_waddr/osd_wdata with osd_wreq = 1 in cycle T+1 (1-cycle latency, same for fill writes).
  - Host address is not range-checked; it is passed unchanged.
- Abort:
  - Sampled only in FILL.
  - The cycle abort = 1 issues no fill write (a host write may still proceed).
  - The FSM goes to DONE; done pulses, err is unchanged.
  - Abort in IDLE is ignored.
- Simultaneous events:
  - A cmd_valid that arrives while FILL is active waits (cmd_ready = 0).
  - Host and fill never both write in one cycle.
  - osd_wreq is 0 in any cycle with no grant; waddr/wdata hold their last value.

Test Plan:
- Reset, then host writes to 0x0010 = 0xDEADBEEF with no fill active -> hst_wack = 1 same cycle; next cycle osd_wreq = 1, osd_waddr = 0x0010, osd_wdata = 0xDEADBEEF.
- Fill x = 2, y = 3, w = 3, h = 2, pitch = 10, color = 0x5, no host traffic -> 6 consecutive writes to addresses 32, 33, 34, 42, 43, 44, all data 0x55555555; done pulses once; busy was high for exactly 6 cycles.
- Same fill with hst_wreq held high continuously, C_HOST_MAX_RUN = 4 -> repeating pattern of 4 host writes then 1 fill write; all 6 fill addresses written; total 30 write cycles.
- Fill with y = 4000, h = 10, pitch = 10 (end beyond 32767) -> no osd_wreq; err = 1; done pulses; next valid command clears err.
- Abort after 2 fill writes of a 9-word fill -> exactly 2 fill writes on the port; done pulses; return to IDLE; cmd_ready = 1.
- Null commands (w = 0, then h = 0) -> no writes, done pulses each time, err stays 0; rst asserted mid-fill -> all outputs 0 next cycle, no further writes.
